// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read 1-write byte-enable register file with clear engine; define REG_FILE_BYPASS_EN for write-to-read forwarding
module reg_file_2r1w #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             w_en,
  input  logic [ADDR_WIDTH-1:0]            w_addr,
  input  logic [DATA_WIDTH-1:0]            w_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] w_be,
  input  logic [ADDR_WIDTH-1:0]            r_addr_a,
  output logic [DATA_WIDTH-1:0]            r_data_a,
  input  logic [ADDR_WIDTH-1:0]            r_addr_b,
  output logic [DATA_WIDTH-1:0]            r_data_b,
  input  logic                             clr_req,
  output logic                             busy,
  output logic                             wr_drop
);
  localparam int D = 2 ** ADDR_WIDTH;
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic                    wr_drop_q, wr_drop_d;
  logic [DATA_WIDTH-1:0]   mem_q [D];
  logic [DATA_WIDTH-1:0]   mem_d [D];
  logic [DATA_WIDTH-1:0]   rd_a, rd_b;
  // next state: clear sweep one entry per edge, lane-masked writes only when idle
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_drop_d = 1'b0;
    mem_d     = mem_q;
    if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = '0;
      clr_ptr_d        = clr_ptr_q + 1'b1;
      wr_drop_d        = w_en;
      if (clr_ptr_q == ADDR_WIDTH'(D - 1)) state_d = IDLE;
    end else begin
      if (w_en)
        for (int i = 0; i < NB; i++)
          if (w_be[i]) mem_d[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] = w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (clr_req) begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    end
  end
  // control state: reset always restarts a full sweep from entry 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end
  // storage is left unreset; the clear engine initialises it
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
  // combinational reads, forced to zero while the sweep runs
  always_comb begin
    rd_a = mem_q[r_addr_a];
    rd_b = mem_q[r_addr_b];
`ifdef REG_FILE_BYPASS_EN
    for (int i = 0; i < NB; i++) begin
      if (w_en && state_q == IDLE && w_be[i] && w_addr == r_addr_a)
        rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (w_en && state_q == IDLE && w_be[i] && w_addr == r_addr_b)
        rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
`endif
    r_data_a = (state_q == CLEAR) ? '0 : rd_a;
    r_data_b = (state_q == CLEAR) ? '0 : rd_b;
  end
  assign busy    = (state_q == CLEAR);
  assign wr_drop = wr_drop_q;
endmodule
